// File: rtl/fractal_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : fractal_dispatcher
// Purpose  : Walks an X_SIZE x Y_SIZE frame, issues per-pixel complex start
//            points round-robin to CORE_COUNT iteration cores, collects the
//            results in issue (raster) order, colour-maps them and presents
//            them as a valid/ready pixel stream with SOF/EOL flags.
// Options  : FRACTAL_PALETTE_EN - 3/3/2-bit palette instead of greyscale.
// Revision : 1.0 - initial release
// ============================================================================
module fractal_dispatcher #(
  parameter int X_SIZE         = 640,
  parameter int Y_SIZE         = 480,
  parameter int CORE_COUNT     = 9,
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_ITER_WIDTH = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               enable_i,
  input  logic                               cfg_julia_i,
  input  logic [DATA_WIDTH-1:0]              cfg_x0_i,
  input  logic [DATA_WIDTH-1:0]              cfg_y0_i,
  input  logic [DATA_WIDTH-1:0]              cfg_step_i,
  input  logic [DATA_WIDTH-1:0]              cfg_cx_i,
  input  logic [DATA_WIDTH-1:0]              cfg_cy_i,
  input  logic [MAX_ITER_WIDTH-1:0]          cfg_max_iter_i,
  output logic [CORE_COUNT-1:0]              core_start_o,
  output logic [CORE_COUNT*DATA_WIDTH-1:0]   core_x0_o,
  output logic [CORE_COUNT*DATA_WIDTH-1:0]   core_y0_o,
  output logic                               core_julia_o,
  output logic [DATA_WIDTH-1:0]              core_cx_o,
  output logic [DATA_WIDTH-1:0]              core_cy_o,
  output logic [MAX_ITER_WIDTH-1:0]          core_max_iter_o,
  input  logic [CORE_COUNT-1:0]              core_done_i,
  input  logic [CORE_COUNT*MAX_ITER_WIDTH-1:0] core_iter_i,
  output logic [7:0]                         pix_r_o,
  output logic [7:0]                         pix_g_o,
  output logic [7:0]                         pix_b_o,
  output logic                               pix_sof_o,
  output logic                               pix_eol_o,
  output logic                               pix_valid_o,
  input  logic                               pix_ready_i,
  output logic                               frame_done_o,
  output logic                               busy_o
);

  localparam int XW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
  localparam int YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
  localparam int CW = $clog2(CORE_COUNT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                    state;
  logic [XW-1:0]             x;
  logic [YW-1:0]             y;
  logic [DATA_WIDTH-1:0]     re;
  logic [DATA_WIDTH-1:0]     im;
  logic [DATA_WIDTH-1:0]     x0_q;
  logic [DATA_WIDTH-1:0]     step_q;
  logic [CW-1:0]             ip;
  logic [CW-1:0]             cp;
  logic [CORE_COUNT-1:0]     busy;
  logic [CORE_COUNT-1:0]     tag_sof;
  logic [CORE_COUNT-1:0]     tag_eol;
  logic [CORE_COUNT-1:0]     tag_last;
  logic                      pix_last;

  logic                      issue_eol;
  logic                      issue_last;
  logic                      can_issue;
  logic                      can_collect;
  logic                      accept;
  logic                      start_frame;
  logic [CORE_COUNT-1:0]     issue_mask;
  logic [CORE_COUNT-1:0]     collect_mask;
  logic [MAX_ITER_WIDTH-1:0] col_iter;
  logic [7:0]                map_r;
  logic [7:0]                map_g;
  logic [7:0]                map_b;

  // Issue/collect decisions and colour mapping of the result under the collect pointer.
  // A core whose start pulse is on the wire this cycle still shows the done level of
  // its previous job, so it is masked out of collection for that one cycle.
  always_comb begin
    issue_eol    = (x == XW'(X_SIZE - 1));
    issue_last   = issue_eol && (y == YW'(Y_SIZE - 1));
    can_issue    = (state == RUN) && !busy[ip];
    accept       = pix_valid_o && pix_ready_i;
    can_collect  = busy[cp] && core_done_i[cp] && !core_start_o[cp] &&
                   (!pix_valid_o || pix_ready_i);
    start_frame  = enable_i && ((state == IDLE) ||
                   ((state == DRAIN) && accept && pix_last));
    issue_mask   = '0;
    collect_mask = '0;
    if (can_issue)   issue_mask[ip]   = 1'b1;
    if (can_collect) collect_mask[cp] = 1'b1;
    col_iter = core_iter_i[cp*MAX_ITER_WIDTH +: MAX_ITER_WIDTH];
`ifdef FRACTAL_PALETTE_EN
    map_r = {col_iter[2:0], 5'b0};
    map_g = {col_iter[5:3], 5'b0};
    map_b = {col_iter[7:6], 6'b0};
`else
    map_r = col_iter[7:0];
    map_g = col_iter[7:0];
    map_b = col_iter[7:0];
`endif
    if (col_iter >= core_max_iter_o) begin
      map_r = 8'd0;
      map_g = 8'd0;
      map_b = 8'd0;
    end
  end

  // Frame sequencer, issue counters, core bookkeeping and the output register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= IDLE;
      x               <= '0;
      y               <= '0;
      re              <= '0;
      im              <= '0;
      x0_q            <= '0;
      step_q          <= '0;
      ip              <= '0;
      cp              <= '0;
      busy            <= '0;
      tag_sof         <= '0;
      tag_eol         <= '0;
      tag_last        <= '0;
      pix_last        <= 1'b0;
      core_start_o    <= '0;
      core_x0_o       <= '0;
      core_y0_o       <= '0;
      core_julia_o    <= 1'b0;
      core_cx_o       <= '0;
      core_cy_o       <= '0;
      core_max_iter_o <= '0;
      pix_r_o         <= '0;
      pix_g_o         <= '0;
      pix_b_o         <= '0;
      pix_sof_o       <= 1'b0;
      pix_eol_o       <= 1'b0;
      pix_valid_o     <= 1'b0;
      frame_done_o    <= 1'b0;
    end else begin
      core_start_o <= '0;
      frame_done_o <= accept && pix_last;
      busy         <= (busy | issue_mask) & ~collect_mask;

      case (state)
        IDLE:    if (start_frame) state <= RUN;
        RUN:     if (can_issue && issue_last) state <= DRAIN;
        DRAIN:   if (accept && pix_last) state <= enable_i ? RUN : IDLE;
        default: state <= IDLE;
      endcase

      // Configuration is only sampled at a frame boundary
      if (start_frame) begin
        core_julia_o    <= cfg_julia_i;
        core_cx_o       <= cfg_cx_i;
        core_cy_o       <= cfg_cy_i;
        core_max_iter_o <= cfg_max_iter_i;
        x0_q            <= cfg_x0_i;
        step_q          <= cfg_step_i;
        re              <= cfg_x0_i;
        im              <= cfg_y0_i;
        x               <= '0;
        y               <= '0;
      end else if (can_issue) begin
        core_start_o[ip]                         <= 1'b1;
        core_x0_o[ip*DATA_WIDTH +: DATA_WIDTH]   <= re;
        core_y0_o[ip*DATA_WIDTH +: DATA_WIDTH]   <= im;
        tag_sof[ip]  <= (x == '0) && (y == '0);
        tag_eol[ip]  <= issue_eol;
        tag_last[ip] <= issue_last;
        ip <= (ip == CW'(CORE_COUNT - 1)) ? '0 : ip + 1'b1;
        if (issue_eol) begin
          x  <= '0;
          re <= x0_q;
          y  <= y + 1'b1;
          im <= im - step_q;
        end else begin
          x  <= x + 1'b1;
          re <= re + step_q;
        end
      end

      if (can_collect) begin
        pix_valid_o <= 1'b1;
        pix_r_o     <= map_r;
        pix_g_o     <= map_g;
        pix_b_o     <= map_b;
        pix_sof_o   <= tag_sof[cp];
        pix_eol_o   <= tag_eol[cp];
        pix_last    <= tag_last[cp];
        cp <= (cp == CW'(CORE_COUNT - 1)) ? '0 : cp + 1'b1;
      end else if (accept) begin
        pix_valid_o <= 1'b0;
      end
    end
  end

  assign busy_o = (|busy) || (state != IDLE) || pix_valid_o;

endmodule
`default_nettype wire

// File: tb/tb_fractal_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_fractal_dispatcher
// Purpose  : Directed self-checking bench for fractal_dispatcher on a 4x2
//            frame with three model cores of programmable latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fractal_dispatcher;

  localparam int XS = 4;
  localparam int YS = 2;
  localparam int NC = 3;
  localparam int DW = 32;
  localparam int IW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic            cfg_julia;
  logic [DW-1:0]   cfg_x0, cfg_y0, cfg_step, cfg_cx, cfg_cy;
  logic [IW-1:0]   cfg_max_iter;
  logic [NC-1:0]   core_start;
  logic [NC*DW-1:0] core_x0, core_y0;
  logic            core_julia;
  logic [DW-1:0]   core_cx, core_cy;
  logic [IW-1:0]   core_max_iter;
  logic [NC-1:0]   core_done;
  logic [NC*IW-1:0] core_iter;
  logic [7:0]      pix_r, pix_g, pix_b;
  logic            pix_sof, pix_eol, pix_valid, pix_ready;
  logic            frame_done, busy;

  fractal_dispatcher #(
    .X_SIZE(XS), .Y_SIZE(YS), .CORE_COUNT(NC), .DATA_WIDTH(DW), .MAX_ITER_WIDTH(IW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .cfg_julia_i(cfg_julia),
    .cfg_x0_i(cfg_x0), .cfg_y0_i(cfg_y0), .cfg_step_i(cfg_step),
    .cfg_cx_i(cfg_cx), .cfg_cy_i(cfg_cy), .cfg_max_iter_i(cfg_max_iter),
    .core_start_o(core_start), .core_x0_o(core_x0), .core_y0_o(core_y0),
    .core_julia_o(core_julia), .core_cx_o(core_cx), .core_cy_o(core_cy),
    .core_max_iter_o(core_max_iter), .core_done_i(core_done), .core_iter_i(core_iter),
    .pix_r_o(pix_r), .pix_g_o(pix_g), .pix_b_o(pix_b), .pix_sof_o(pix_sof),
    .pix_eol_o(pix_eol), .pix_valid_o(pix_valid), .pix_ready_i(pix_ready),
    .frame_done_o(frame_done), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Per-pixel iteration results and per-core latency, set by the stimulus
  logic [IW-1:0] res_tab [8];
  int            lat [NC];

  // Model core: result picked by pixel position decoded from its start point
  // (valid for x0=y0=0 and step=1.0: x in bits 25:24, any nonzero imag = row 1)
  function automatic int pix_idx(input logic [DW-1:0] px, input logic [DW-1:0] py);
    return int'(px[25:24]) + ((py != '0) ? 4 : 0);
  endfunction

  int            cnt [NC];
  logic [NC-1:0] mbusy;

  // Model cores: done is a level held from completion until the next start
  always @(posedge clk) begin
    for (int k = 0; k < NC; k++) begin
      if (rst) begin
        core_done[k] <= 1'b0;
        cnt[k]       <= 0;
        mbusy[k]     <= 1'b0;
        core_iter[k*IW +: IW] <= '0;
      end else if (core_start[k]) begin
        mbusy[k]     <= 1'b1;
        core_done[k] <= 1'b0;
        cnt[k]       <= lat[k];
        core_iter[k*IW +: IW] <= res_tab[pix_idx(core_x0[k*DW +: DW], core_y0[k*DW +: DW])];
      end else if (cnt[k] == 1) begin
        cnt[k]       <= 0;
        core_done[k] <= 1'b1;
        mbusy[k]     <= 1'b0;
      end else if (cnt[k] > 1) begin
        cnt[k] <= cnt[k] - 1;
      end
    end
  end

  // Stream observers: accepted pixels, issued start points, stall stability
  logic [25:0] px_q [$];
  logic [63:0] st_q [$];
  int          fd_cnt = 0;
  int          busy_viol = 0;
  int          stall_viol = 0;
  logic        prev_stall = 1'b0;
  logic [25:0] prev_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (pix_valid && pix_ready) px_q.push_back({pix_r, pix_g, pix_b, pix_sof, pix_eol});
      if (frame_done) fd_cnt++;
      for (int k = 0; k < NC; k++) begin
        if (core_start[k]) begin
          st_q.push_back({core_x0[k*DW +: DW], core_y0[k*DW +: DW]});
          if (mbusy[k]) busy_viol++;
        end
      end
      if (prev_stall && (!pix_valid || ({pix_r, pix_g, pix_b, pix_sof, pix_eol} != prev_data)))
        stall_viol++;
      prev_stall = pix_valid && !pix_ready;
      prev_data  = {pix_r, pix_g, pix_b, pix_sof, pix_eol};
    end
  end

  int passed = 0;
  int total  = 0;
  int failed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [25:0] exp_pix(input int i, input logic [IW-1:0] it, input logic [IW-1:0] mx);
    logic [7:0] r, g, b;
    if (it >= mx) begin
      r = 8'd0; g = 8'd0; b = 8'd0;
    end else begin
`ifdef FRACTAL_PALETTE_EN
      r = {it[2:0], 5'b0};
      g = {it[5:3], 5'b0};
      b = {it[7:6], 6'b0};
`else
      r = it[7:0]; g = it[7:0]; b = it[7:0];
`endif
    end
    return {r, g, b, (i == 0), ((i % XS) == XS - 1)};
  endfunction

  task automatic start_frame();
    @(posedge clk); #1 enable = 1'b1;
    @(posedge clk); #1 enable = 1'b0;
  endtask

  task automatic wait_frame(input string tag, input int pxb, input int fdb, input bit toggle);
    int cyc = 0;
    bit ok  = 1'b0;
    while (cyc < 400 && !ok) begin
      @(posedge clk); #1;
      if (toggle) pix_ready = ((cyc % 3) == 0);
      cyc++;
      if (px_q.size() >= pxb + 8 && fd_cnt > fdb) ok = 1'b1;
    end
    repeat (6) @(posedge clk);
    #1 pix_ready = 1'b1;
    chk({tag, "_complete"}, 64'(ok), 64'd1);
  endtask

  task automatic check_frame(input string tag, input int pxb, input int fdb, input logic [IW-1:0] mx);
    chk({tag, "_pixel_count"}, 64'(px_q.size() - pxb), 64'd8);
    chk({tag, "_frame_done_once"}, 64'(fd_cnt - fdb), 64'd1);
    for (int i = 0; i < 8; i++)
      if (pxb + i < px_q.size())
        chk($sformatf("%s_pix%0d", tag, i), 64'(px_q[pxb + i]), 64'(exp_pix(i, res_tab[i], mx)));
  endtask

  int pxb, fdb, stb, wd;
  logic [25:0] p;

  initial begin
    rst = 1'b1; enable = 1'b0; pix_ready = 1'b1;
    cfg_julia = 1'b0; cfg_x0 = '0; cfg_y0 = '0; cfg_step = 32'h0100_0000;
    cfg_cx = '0; cfg_cy = '0; cfg_max_iter = 16'd100;
    for (int i = 0; i < 8; i++) res_tab[i] = 16'(10 * i + 3);
    for (int k = 0; k < NC; k++) lat[k] = 5;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_valid", 64'(pix_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_start", 64'(core_start), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_rgb", 64'({pix_r, pix_g, pix_b}), 64'd0);

    // Frame 1: equal latency, ready always high, check start points and 1-cycle collect latency
    pxb = px_q.size(); fdb = fd_cnt; stb = st_q.size();
    start_frame();
    chk("run_busy", 64'(busy), 64'd1);
    wd = 0;
    @(negedge clk);
    while (!core_done[0] && wd < 50) begin @(negedge clk); wd++; end
    chk("first_done_seen", 64'(core_done[0]), 64'd1);
    chk("empty_before_collect", 64'(pix_valid), 64'd0);
    @(negedge clk);
    chk("collect_latency", 64'({pix_valid, pix_sof}), 64'b11);
    wait_frame("f1", pxb, fdb, 1'b0);
    check_frame("f1", pxb, fdb, 16'd100);
    chk("f1_start_count", 64'(st_q.size() - stb), 64'd8);
    for (int i = 0; i < 8; i++)
      if (stb + i < st_q.size())
        chk($sformatf("f1_start%0d", i), st_q[stb + i],
            {32'(i % 4) << 24, (i < 4) ? 32'h0 : 32'hFF00_0000});
    chk("f1_idle_busy", 64'(busy), 64'd0);

    // Frame 2: unequal latencies, order must stay raster
    lat[0] = 9; lat[1] = 2; lat[2] = 4;
    for (int i = 0; i < 8; i++) res_tab[i] = 16'(7 * i + 1);
    pxb = px_q.size(); fdb = fd_cnt;
    start_frame();
    wait_frame("f2", pxb, fdb, 1'b0);
    check_frame("f2", pxb, fdb, 16'd100);
    chk("f2_no_start_while_busy", 64'(busy_viol), 64'd0);

    // Frame 3: backpressure, ready high one cycle in three
    lat[0] = 5; lat[1] = 5; lat[2] = 5;
    pxb = px_q.size(); fdb = fd_cnt;
    start_frame();
    wait_frame("f3", pxb, fdb, 1'b1);
    check_frame("f3", pxb, fdb, 16'd100);
    chk("f3_stall_stable", 64'(stall_viol), 64'd0);

    // Frame 4: Julia mode, configuration changed mid-frame is ignored
    cfg_julia = 1'b1; cfg_cx = 32'h0040_0000; cfg_cy = 32'hFFC0_0000;
    pxb = px_q.size(); fdb = fd_cnt;
    start_frame();
    repeat (3) @(posedge clk);
    #1;
    cfg_julia = 1'b0; cfg_cx = 32'h1111_1111; cfg_cy = 32'h2222_2222;
    cfg_step = 32'h0080_0000; cfg_max_iter = 16'd5;
    repeat (2) @(posedge clk);
    #1;
    chk("julia_mode", 64'(core_julia), 64'd1);
    chk("julia_cx", 64'(core_cx), 64'h0040_0000);
    chk("julia_cy", 64'(core_cy), 64'hFFC0_0000);
    wait_frame("f4", pxb, fdb, 1'b0);
    check_frame("f4", pxb, fdb, 16'd100);
    chk("julia_cx_after", 64'(core_cx), 64'h0040_0000);

    // Frame 5: inside pixels and colour map at max_iter=70
    cfg_julia = 1'b0; cfg_cx = 32'h1234_5678; cfg_cy = '0;
    cfg_step = 32'h0100_0000; cfg_max_iter = 16'd70;
    res_tab[0] = 16'd70;  res_tab[1] = 16'h002D; res_tab[2] = 16'd71;  res_tab[3] = 16'd69;
    res_tab[4] = 16'd0;   res_tab[5] = 16'h00FF; res_tab[6] = 16'h0100; res_tab[7] = 16'd5;
    pxb = px_q.size(); fdb = fd_cnt;
    start_frame();
    chk("relatch_cx", 64'(core_cx), 64'h1234_5678);
    chk("relatch_max_iter", 64'(core_max_iter), 64'd70);
    wait_frame("f5", pxb, fdb, 1'b0);
    check_frame("f5", pxb, fdb, 16'd70);
    if (pxb + 1 < px_q.size()) begin
      p = px_q[pxb];
      chk("inside_black", 64'(p[25:2]), 64'h000000);
      p = px_q[pxb + 1];
`ifdef FRACTAL_PALETTE_EN
      chk("iter_2d_colour", 64'(p[25:2]), 64'hA0A000);
`else
      chk("iter_2d_colour", 64'(p[25:2]), 64'h2D2D2D);
`endif
    end

    // Frame 6: reset mid-frame, then a fresh frame must start with SOF
    for (int i = 0; i < 8; i++) res_tab[i] = 16'(i + 20);
    cfg_max_iter = 16'd100;
    start_frame();
    repeat (12) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midrst_valid", 64'(pix_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_start", 64'(core_start), 64'd0);
    chk("midrst_cx", 64'(core_cx), 64'd0);
    pxb = px_q.size(); fdb = fd_cnt;
    start_frame();
    wait_frame("f6", pxb, fdb, 1'b0);
    check_frame("f6", pxb, fdb, 16'd100);
    if (pxb < px_q.size()) begin
      p = px_q[pxb];
      chk("post_rst_sof", 64'(p[1]), 64'd1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fractal_dispatcher.md
# fractal_dispatcher

Parametrised pixel scheduler between the register file and the fractal core array. Walks an X_SIZE×Y_SIZE frame, issues per-pixel complex coordinates round-robin to CORE_COUNT iteration cores (Mandelbrot or Julia), and collects results strictly in issue order. It colour-maps the results and presents them as a valid/ready pixel stream with start-of-frame and end-of-line flags for the packer. It replaces the fixed nine-core, Mandelbrot-only dispatch with runtime-selectable mode, origin, step and iteration limit.

## Interface
- X_SIZE, 640, pixels per line
- Y_SIZE, 480, lines per frame
- CORE_COUNT, 9, attached cores (≥2)
- DATA_WIDTH, 32, signed fixed-point coordinate width (8.24)
- MAX_ITER_WIDTH, 16, iteration count width
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high; must also reset the attached cores
- enable_i  in  1  run frames continuously while high
- cfg_julia_i  in  1  0 Mandelbrot, 1 Julia
- cfg_x0_i, cfg_y0_i  in  DATA_WIDTH  top-left real/imag coordinate
- cfg_step_i  in  DATA_WIDTH  coordinate increment per pixel/line
- cfg_cx_i, cfg_cy_i  in  DATA_WIDTH  Julia constant
- cfg_max_iter_i  in  MAX_ITER_WIDTH  iteration limit
- core_start_o  out  CORE_COUNT  one-cycle start pulse per core
- core_x0_o, core_y0_o  out  CORE_COUNT×DATA_WIDTH  per-core start point, core k at slice k
- core_julia_o  out  1; core_cx_o, core_cy_o  out  DATA_WIDTH; core_max_iter_o  out  MAX_ITER_WIDTH  latched frame config
- core_done_i  in  CORE_COUNT  level; held from completion until next start
- core_iter_i  in  CORE_COUNT×MAX_ITER_WIDTH  per-core result
- pix_r_o, pix_g_o, pix_b_o  out  8  colour
- pix_sof_o, pix_eol_o  out  1  first pixel of frame / last pixel of line
- pix_valid_o  out  1; pix_ready_i  in  1  stream handshake
- frame_done_o  out  1  pulse on final pixel accepted
- busy_o  out  1  any core busy or frame in progress

## Operation
- State machine: IDLE → RUN → DRAIN → IDLE.
  - IDLE → RUN: when enable_i=1. Latch all cfg_* in that cycle; reset issue counters x=0, y=0, re=cfg_x0, im=cfg_y0.
  - RUN → DRAIN: after the issue of pixel (X_SIZE-1, Y_SIZE-1).
  - DRAIN → RUN (new frame, config re-latched): last pixel accepted and enable_i=1.
  - DRAIN → IDLE: last pixel accepted and enable_i=0.
- cfg_* changes mid-frame are ignored. Deasserting enable_i mid-frame still completes the frame.
- Issue: issue pointer ip. In RUN, if busy[ip]=0, pulse core_start_o[ip], drive its x0/y0 slice with re/im, and store sof/eol tag[ip]. Then set busy[ip], ip = (ip+1) mod CORE_COUNT, and advance the counters.
  - Not eol: x+1, re += step.
  - eol: x=0, re=x0, y+1, im -= step.
  - Accumulators wrap two's complement; no saturation.
- Collect: collect pointer cp. If busy[cp] & core_done_i[cp] & (output empty or pix_ready_i), load the output register with the colour-mapped core_iter_i[cp] and tag[cp]. Then clear busy[cp] and advance cp mod CORE_COUNT.
- Issue and collect are both round-robin, so output order equals raster order regardless of core finish order.
- Inside pixel: iter ≥ latched max_iter → r=g=b=0.
- Output register: pix_valid_o held with data stable until pix_ready_i. One pixel is accepted per cycle when ready stays high.
- Reset: all outputs 0, busy=0, ip=cp=0, state IDLE. Reset mid-frame abandons the frame; the next frame starts with sof.

## Timing
- Issue rate ≤1 core start per cycle. A core freed by collect in cycle n can be reissued in cycle n+1.
- core_start_o is registered: it is high the cycle after the issue decision, and x0/y0 are valid in that same cycle.
- core_done_i[cp] high → pix_valid_o high next cycle (1-cycle latency) when the output is empty.
- A simultaneous collect and issue on the same core index in one cycle is not allowed. Issue sees busy as registered, so the index is reissued at the earliest the next cycle.
- frame_done_o pulses the cycle after the handshake of the pixel with x=X_SIZE-1, y=Y_SIZE-1.

## Configuration
- FRACTAL_PALETTE_EN defined: r={iter[2:0],5'b0}, g={iter[5:3],5'b0}, b={iter[7:6],6'b0}.
- Undefined: greyscale, r=g=b=iter[7:0].
- Inside pixels are black in both cases.

## Test plan
- Bench uses X_SIZE=4, Y_SIZE=2, CORE_COUNT=3, model cores with programmable latency.
- Equal latency 5, pix_ready_i=1, x0=0, y0=0, step=0x0100_0000: 8 pixels in raster order. Core x0 sequence 0,1,2,3,0,1,2,3 (8.24). y0 0 for row 0, −1.0 for row 1. sof on pixel 0; eol on pixels 3 and 7; frame_done_o once.
- Core latencies 9,2,4: output order still raster order; no core started while busy.
- pix_ready_i toggled 1-in-3: pix_valid_o/data never change while stalled; all 8 pixels delivered once.
- Julia mode, cx=0x0040_0000, cy=0xFFC0_0000, cfg changed mid-frame: core_cx_o/core_cy_o keep the frame-start values until the next frame.
- iter=70=max_iter → 0,0,0. iter=0x2D → palette (0xA0,0xA0,0x00) with macro, grey 0x2D without.
- rst_i asserted mid-frame for 1 cycle: outputs 0, busy_o=0 next cycle. The next pixel emitted has pix_sof_o=1.
